acc_result_writer: RTL and testbench

Consumer end of the accumulator output in the 32x32 matrix datapath. Captures each completed Q11.21 dot-product sum when the accumulator pulses `flag`. Buffers sums in a small FIFO. Writes them in row-major order into the result-matrix memory over a we/ready handshake, and signals `done` once all N*N results are written.

---
 rtl/matrix_pkg.sv | 18 +
 rtl/acc_fifo.sv | 56 +++++
 rtl/acc_result_writer.sv | 111 +++++++++++
 tb/tb_acc_result_writer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants and types for the 32x32 matrix datapath
package matrix_pkg;

  localparam int N  = 32;
  localparam int W  = 32;
  localparam int AW = $clog2(N * N);

  // Sums are signed Q11.21: integer bits [31:21], fraction bits [20:0].
  localparam int INT_BITS  = 11;
  localparam int FRAC_BITS = 21;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/acc_fifo.sv
// rtl/acc_fifo.sv - synchronous DEPTH x W FIFO buffering completed accumulator sums
module acc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0]   FULL_CNT = DEPTH[PW:0];
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop never frees a slot.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/acc_result_writer.sv
// rtl/acc_result_writer.sv - captures accumulator sums on flag and writes them row-major to result memory
module acc_result_writer #(
  parameter int N     = matrix_pkg::N,
  parameter int W     = matrix_pkg::W,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(N * N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flag,
  input  logic signed [W-1:0] acc,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [W-1:0]        mem_data,
  input  logic                mem_ready,
  output logic                busy,
  output logic                done,
  output logic                ovf
);

  import matrix_pkg::*;

  localparam int NN = N * N;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CAP_MAX  = CW'(NN);
  localparam logic [AW-1:0] LAST_IDX = AW'(NN - 1);
  localparam logic [CW-1:0] CAP_ONE  = CW'(1);
  localparam logic [AW-1:0] IDX_ONE  = AW'(1);

  state_t        r_state;
  state_t        w_next_state;
  logic [CW-1:0] r_cap;
  logic [AW-1:0] r_wr_idx;
  logic          r_ovf;

  logic          w_start_acc;
  logic          w_run;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [W-1:0]  w_fifo_data;

  assign w_run       = (r_state == RUN);
  assign w_start_acc = start && (r_state == IDLE);
  assign w_push      = w_run && flag && !w_fifo_full && (r_cap != CAP_MAX);
  assign w_pop       = mem_we && mem_ready;

  acc_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_acc),
    .i_push  (w_push),
    .i_data  (acc),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_pop && (r_wr_idx == LAST_IDX)) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    mem_we = 1'b0;
    case (r_state)
      RUN: begin
        busy   = 1'b1;
        mem_we = !w_fifo_empty;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Capture count, write index and sticky overflow; flags outside RUN are ignored.
  always_ff @(posedge clk) begin
    if (rst || w_start_acc) begin
      r_cap    <= '0;
      r_wr_idx <= '0;
      r_ovf    <= 1'b0;
    end else if (w_run) begin
      if (w_push)     r_cap <= r_cap + CAP_ONE;
      else if (flag)  r_ovf <= 1'b1;
      if (w_pop)      r_wr_idx <= r_wr_idx + IDX_ONE;
    end
  end

  assign mem_addr = r_wr_idx;
  assign mem_data = mem_we ? w_fifo_data : '0;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_acc_result_writer.sv
// tb/tb_acc_result_writer.sv - randomized self-checking bench for acc_result_writer (N=2)
module tb_acc_result_writer;

  localparam int N     = 2;
  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int NN    = N * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          flag;
  logic [W-1:0]  acc;
  logic          mem_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [W-1:0]  mem_data;
  logic          busy;
  logic          done;
  logic          ovf;

  acc_result_writer #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .flag      (flag),
    .acc       (acc),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frame phase (0 idle, 1 running, 2 finished), buffered sums, counters.
  int           m_state = 0;
  logic [W-1:0] m_q[$];
  logic [W-1:0] m_frame[$];
  int           m_cap   = 0;
  int           m_widx  = 0;
  bit           m_ovf   = 1'b0;
  logic [W-1:0] dut_mem [NN];

  task automatic frame_check();
    check("frame_len", 64'(m_frame.size()), 64'(NN));
    for (int i = 0; i < m_frame.size() && i < NN; i++)
      check("frame_data", dut_mem[i], m_frame[i]);
  endtask

  task automatic step(input bit r, input bit s, input bit f, input logic [W-1:0] a, input bit rdy);
    bit exp_we;
    bit full;
    bit pop;
    rst = r; start = s; flag = f; acc = a; mem_ready = rdy;
    #1;
    exp_we = (m_state == 1) && (m_q.size() > 0);
    check("busy", busy, 64'(m_state == 1));
    check("done", done, 64'(m_state == 2));
    check("mem_we", mem_we, 64'(exp_we));
    check("ovf", ovf, 64'(m_ovf));
    if (exp_we) begin
      check("mem_addr", mem_addr, 64'(m_widx));
      check("mem_data", mem_data, m_q[0]);
    end
    if (mem_we === 1'b1 && rdy) dut_mem[mem_addr] = mem_data;
    @(posedge clk);
    if (r) begin
      m_state = 0; m_q.delete(); m_cap = 0; m_widx = 0; m_ovf = 1'b0;
    end else begin
      case (m_state)
        0: if (s) begin
          m_state = 1; m_q.delete(); m_frame.delete();
          m_cap = 0; m_widx = 0; m_ovf = 1'b0;
          for (int i = 0; i < NN; i++) dut_mem[i] = 'x;
        end
        1: begin
          full = (m_q.size() == DEPTH);
          pop  = exp_we && rdy;
          if (f) begin
            if (!full && m_cap < NN) begin
              m_q.push_back(a); m_frame.push_back(a); m_cap++;
            end else m_ovf = 1'b1;
          end
          if (pop) begin
            void'(m_q.pop_front());
            if (m_widx == NN - 1) m_state = 2;
            m_widx++;
          end
        end
        default: begin
          m_state = 0;
          frame_check();
        end
      endcase
    end
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, rdy);
  endtask

  logic [W-1:0] basic_vals [4];

  initial begin
    basic_vals[0] = 32'h0020_0000;
    basic_vals[1] = 32'hFFE0_0000;
    basic_vals[2] = 32'h7FFF_FFFF;
    basic_vals[3] = 32'h8000_0000;
    rst = 1'b1; start = 1'b0; flag = 1'b0; acc = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);

    // Flags in IDLE are ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    idle(2, 1'b1);

    // Basic frame.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, basic_vals[i], 1'b1);
    idle(4, 1'b1);
    check("basic_mem3", dut_mem[3], 32'h8000_0000);

    // Backpressure: ten cycles without ready while four sums arrive.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    idle(6, 1'b0);
    check("bp_no_ovf", ovf, 0);
    idle(8, 1'b1);

    // Overflow: five sums into a four-deep buffer.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, W'(i), 1'b0);
    idle(2, 1'b0);
    idle(8, 1'b1);
    check("ovf_sticky", ovf, 1);
    check("ovf_mem0", dut_mem[0], 1);

    // Excess flag after the frame quota is captured.
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    idle(4, 1'b1);
    check("excess_ovf", ovf, 1);

    // Mid-frame reset, then a fresh frame from address 0.
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    check("midrst_we", mem_we, 0);
    idle(2, 1'b1);
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom, 1'b1);
    idle(4, 1'b1);

    // Randomized frames with backpressure, stray starts and occasional reset.
    for (int fr = 0; fr < 40; fr++) begin
      step(1'b0, 1'b1, 1'b0, '0, 1'b1);
      for (int c = 0; c < 200 && m_state != 0; c++) begin
        if ($urandom_range(0, 99) == 0) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        else step(1'b0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                  $urandom, $urandom_range(0, 3) != 0);
      end
      if (m_state != 0) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        step(1'b0, 1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
